knn_vote: RTL and testbench



---
 rtl/knn_vote.sv | 177 +++++++++++++++++
 tb/tb_knn_vote.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_vote.sv
// knn_vote: reads the K-nearest list once, builds a per-class vote histogram and reports the majority class.
// Optional feature macro KNN_VOTE_NEAREST_TIE_EN: equal vote counts are broken by the smaller nearest distance.
module knn_vote #(
  parameter int DATA_W      = 32,
  parameter int NBR_KNN     = 4,
  parameter int LABEL_BITS  = 8,
  parameter int NBR_CLASSES = 10,
  localparam int AW = (NBR_KNN > 1) ? $clog2(NBR_KNN) : 1,
  localparam int CW = $clog2(NBR_KNN + 1),
  localparam int SW = (NBR_CLASSES > 1) ? $clog2(NBR_CLASSES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  rd_en,
  output logic [AW-1:0]         rd_addr,
  input  logic [DATA_W-1:0]     nn_dist,
  input  logic [LABEL_BITS-1:0] nn_label,
  output logic                  busy,
  output logic                  done,
  output logic [LABEL_BITS-1:0] label_out,
  output logic [CW-1:0]         vote_cnt
);

  typedef enum logic [2:0] {IDLE, CLEAR, READ, DRAIN, SCAN, DONE} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         rdAddr_q, rdAddr_d;
  logic [SW-1:0]         scanIdx_q, scanIdx_d;
  logic                  rdEn_q, acc_q, busy_q, done_q;
  logic [LABEL_BITS-1:0] label_q, label_d, bestLbl_q, bestLbl_d;
  logic [CW-1:0]         vote_q, vote_d, bestCnt_q, bestCnt_d;
  logic [CW-1:0]         cnt_q [NBR_CLASSES];
  logic [CW-1:0]         cnt_d [NBR_CLASSES];
  logic [CW-1:0]         curCnt;
  logic                  entryValid, take;
`ifdef KNN_VOTE_NEAREST_TIE_EN
  logic [DATA_W-1:0]     minDist_q [NBR_CLASSES];
  logic [DATA_W-1:0]     minDist_d [NBR_CLASSES];
  logic [DATA_W-1:0]     bestMin_q, bestMin_d, curMin;
`endif

  // acc_q marks the cycle in which read data requested one cycle earlier is on nn_dist/nn_label
  always_comb begin
    state_d   = state_q;
    rdAddr_d  = rdAddr_q;
    scanIdx_d = scanIdx_q;
    bestCnt_d = bestCnt_q;
    bestLbl_d = bestLbl_q;
    label_d   = label_q;
    vote_d    = vote_q;
    cnt_d     = cnt_q;
    curCnt    = '0;
    for (int i = 0; i < NBR_CLASSES; i++) begin
      if (scanIdx_q == SW'(i)) curCnt = cnt_q[i];
    end
    entryValid = (nn_dist != '1) && (nn_label < LABEL_BITS'(NBR_CLASSES));
    take       = (curCnt > bestCnt_q);
`ifdef KNN_VOTE_NEAREST_TIE_EN
    minDist_d = minDist_q;
    bestMin_d = bestMin_q;
    curMin    = '1;
    for (int i = 0; i < NBR_CLASSES; i++) begin
      if (scanIdx_q == SW'(i)) curMin = minDist_q[i];
    end
    if ((curCnt == bestCnt_q) && (curCnt != '0) && (curMin < bestMin_q)) take = 1'b1;
`endif

    if (acc_q && entryValid) begin
      for (int i = 0; i < NBR_CLASSES; i++) begin
        if (nn_label == LABEL_BITS'(i)) begin
          cnt_d[i] = cnt_q[i] + CW'(1);
`ifdef KNN_VOTE_NEAREST_TIE_EN
          if (nn_dist < minDist_q[i]) minDist_d[i] = nn_dist;
`endif
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        state_d   = READ;
        rdAddr_d  = '0;
        bestCnt_d = '0;
        bestLbl_d = '1;
        for (int i = 0; i < NBR_CLASSES; i++) cnt_d[i] = '0;
`ifdef KNN_VOTE_NEAREST_TIE_EN
        bestMin_d = '1;
        for (int i = 0; i < NBR_CLASSES; i++) minDist_d[i] = '1;
`endif
      end
      READ: begin
        if (rdAddr_q == AW'(NBR_KNN - 1)) begin
          state_d  = DRAIN;
          rdAddr_d = '0;
        end else begin
          rdAddr_d = rdAddr_q + AW'(1);
        end
      end
      DRAIN: begin
        state_d   = SCAN;
        scanIdx_d = '0;
      end
      SCAN: begin
        // bestLbl starts all-ones and only moves on a non-zero count, so an empty list reports all-ones/0
        if (take) begin
          bestCnt_d = curCnt;
          bestLbl_d = LABEL_BITS'(scanIdx_q);
`ifdef KNN_VOTE_NEAREST_TIE_EN
          bestMin_d = curMin;
`endif
        end
        if (scanIdx_q == SW'(NBR_CLASSES - 1)) begin
          state_d = DONE;
          label_d = bestLbl_d;
          vote_d  = bestCnt_d;
        end else begin
          scanIdx_d = scanIdx_q + SW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rdAddr_q  <= '0;
      scanIdx_q <= '0;
      rdEn_q    <= 1'b0;
      acc_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      label_q   <= '0;
      vote_q    <= '0;
      bestCnt_q <= '0;
      bestLbl_q <= '0;
      for (int i = 0; i < NBR_CLASSES; i++) cnt_q[i] <= '0;
`ifdef KNN_VOTE_NEAREST_TIE_EN
      bestMin_q <= '1;
      for (int i = 0; i < NBR_CLASSES; i++) minDist_q[i] <= '1;
`endif
    end else begin
      state_q   <= state_d;
      rdAddr_q  <= rdAddr_d;
      scanIdx_q <= scanIdx_d;
      rdEn_q    <= (state_d == READ);
      acc_q     <= rdEn_q;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      label_q   <= label_d;
      vote_q    <= vote_d;
      bestCnt_q <= bestCnt_d;
      bestLbl_q <= bestLbl_d;
      for (int i = 0; i < NBR_CLASSES; i++) cnt_q[i] <= cnt_d[i];
`ifdef KNN_VOTE_NEAREST_TIE_EN
      bestMin_q <= bestMin_d;
      for (int i = 0; i < NBR_CLASSES; i++) minDist_q[i] <= minDist_d[i];
`endif
    end
  end

  assign rd_en     = rdEn_q;
  assign rd_addr   = rdAddr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign label_out = label_q;
  assign vote_cnt  = vote_q;

endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: table-driven, hand-sequenced and randomized checks of knn_vote against a vote-counting model.
// Honours KNN_VOTE_NEAREST_TIE_EN so the same bench covers both tie-break builds.
module tb_knn_vote;

  localparam int DATA_W      = 32;
  localparam int NBR_KNN     = 4;
  localparam int LABEL_BITS  = 8;
  localparam int NBR_CLASSES = 10;
  localparam int LATENCY     = NBR_KNN + NBR_CLASSES + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [31:0] nn_dist;
  logic [7:0]  nn_label;
  logic        busy;
  logic        done;
  logic [7:0]  label_out;
  logic [2:0]  vote_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] memD [NBR_KNN];
  logic [7:0]  memL [NBR_KNN];
  int          addrLog [$];

  typedef struct {
    string            name;
    logic [3:0][31:0] d;
    logic [3:0][7:0]  l;
    logic [7:0]       expLbl;
    logic [2:0]       expCnt;
  } vec_t;

  vec_t vecs [6];

  knn_vote #(
    .DATA_W(DATA_W), .NBR_KNN(NBR_KNN), .LABEL_BITS(LABEL_BITS), .NBR_CLASSES(NBR_CLASSES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .nn_dist(nn_dist), .nn_label(nn_label), .busy(busy), .done(done),
    .label_out(label_out), .vote_cnt(vote_cnt)
  );

  always #5 clk = ~clk;

  // List bank model: registered read port, one cycle of latency
  always @(posedge clk) begin
    if (rd_en) begin
      nn_dist  <= memD[rd_addr];
      nn_label <= memL[rd_addr];
      addrLog.push_back(int'(rd_addr));
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(string n, logic [31:0] d0, logic [7:0] l0, logic [31:0] d1, logic [7:0] l1,
                                 logic [31:0] d2, logic [7:0] l2, logic [31:0] d3, logic [7:0] l3,
                                 logic [7:0] eL, logic [2:0] eC);
    vec_t v;
    v.name = n;
    v.d[0] = d0; v.l[0] = l0;
    v.d[1] = d1; v.l[1] = l1;
    v.d[2] = d2; v.l[2] = l2;
    v.d[3] = d3; v.l[3] = l3;
    v.expLbl = eL;
    v.expCnt = eC;
    return v;
  endfunction

  // Reference: count votes per valid class, remember each class's nearest distance, pick the winner
  function automatic void refModel(input logic [3:0][31:0] d, input logic [3:0][7:0] l,
                                   output logic [7:0] lbl, output logic [2:0] cnt);
    int              votes [NBR_CLASSES];
    longint unsigned nearest [NBR_CLASSES];
    int              best;
    bit              better;
    for (int c = 0; c < NBR_CLASSES; c++) begin
      votes[c]   = 0;
      nearest[c] = 64'h1_0000_0000;
    end
    for (int j = 0; j < NBR_KNN; j++) begin
      if (d[j] != 32'hFFFF_FFFF && int'(l[j]) < NBR_CLASSES) begin
        votes[l[j]]++;
        if (longint'(d[j]) < nearest[l[j]]) nearest[l[j]] = longint'(d[j]);
      end
    end
    best = -1;
    for (int c = 0; c < NBR_CLASSES; c++) begin
      if (votes[c] > 0) begin
        better = (best < 0) || (votes[c] > votes[best]);
`ifdef KNN_VOTE_NEAREST_TIE_EN
        if (best >= 0 && votes[c] == votes[best] && nearest[c] < nearest[best]) better = 1'b1;
`endif
        if (better) best = c;
      end
    end
    lbl = (best < 0) ? 8'hFF : 8'(best);
    cnt = (best < 0) ? 3'd0 : 3'(votes[best]);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Called at #1 after a clock edge; raises start immediately and returns in the done cycle
  task automatic applyStimulus(input logic [3:0][31:0] d, input logic [3:0][7:0] l, input bit extraStarts,
                               output logic [7:0] lbl, output logic [2:0] cnt, output int lat, output bit busyOk);
    for (int j = 0; j < NBR_KNN; j++) begin
      memD[j] = d[j];
      memL[j] = l[j];
    end
    addrLog.delete();
    busyOk = 1'b1;
    lat    = 0;
    start  = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      start = extraStarts && (n == 3 || n == 8);
      if (busy !== 1'b1) busyOk = 1'b0;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    lbl = label_out;
    cnt = vote_cnt;
  endtask

  initial begin
    logic [7:0]       lbl, mLbl;
    logic [2:0]       cnt, mCnt;
    int               lat, doneSeen, found;
    bit               busyOk, holdOk;
    logic [3:0][31:0] rd;
    logic [3:0][7:0]  rl;

    vecs[0] = mkVec("majority", 10, 3, 20, 3, 30, 5, 40, 7, 8'd3, 3'd2);
`ifdef KNN_VOTE_NEAREST_TIE_EN
    vecs[1] = mkVec("tieBreak", 10, 2, 20, 2, 5, 6, 30, 6, 8'd6, 3'd2);
`else
    vecs[1] = mkVec("tieBreak", 10, 2, 20, 2, 5, 6, 30, 6, 8'd2, 3'd2);
`endif
    vecs[2] = mkVec("allEmpty", 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFF, 4, 8'hFF, 3'd0);
    vecs[3] = mkVec("badLabel", 1, 12, 2, 12, 3, 4, 32'hFFFF_FFFF, 4, 8'd4, 3'd1);
    vecs[4] = mkVec("allSame", 1, 1, 1, 1, 1, 1, 1, 1, 8'd1, 3'd4);
    vecs[5] = mkVec("tieLowIdx", 7, 9, 3, 0, 5, 9, 1, 0, 8'd0, 3'd2);

    for (int j = 0; j < NBR_KNN; j++) begin
      memD[j] = '0;
      memL[j] = '0;
    end
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetRdEn", rd_en, 0);
    checkOutput("resetRdAddr", rd_addr, 0);
    checkOutput("resetLabel", label_out, 0);
    checkOutput("resetVotes", vote_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full timing of one operation: latency, busy window, read order, single-cycle done
    applyStimulus(vecs[0].d, vecs[0].l, 1'b0, lbl, cnt, lat, busyOk);
    checkOutput("majLatency", lat, LATENCY);
    checkOutput("majLabel", lbl, 3);
    checkOutput("majVotes", cnt, 2);
    checkOutput("majBusyWindow", busyOk, 1);
    checkOutput("majReadCount", addrLog.size(), NBR_KNN);
    for (int i = 0; i < NBR_KNN; i++)
      checkOutput("majReadAddr", (i < addrLog.size()) ? addrLog[i] : -1, i);
    @(posedge clk); #1;
    checkOutput("majBusyAfter", busy, 0);
    checkOutput("majDonePulse", done, 0);

    for (int v = 0; v < 6; v++) begin
      repeat (2) @(posedge clk);
      #1;
      applyStimulus(vecs[v].d, vecs[v].l, 1'b0, lbl, cnt, lat, busyOk);
      checkOutput({vecs[v].name, "Latency"}, lat, LATENCY);
      checkOutput({vecs[v].name, "Label"}, lbl, vecs[v].expLbl);
      checkOutput({vecs[v].name, "Votes"}, cnt, vecs[v].expCnt);
    end

    // Starts during an operation are dropped; a start right after done launches a fresh run
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(vecs[3].d, vecs[3].l, 1'b1, lbl, cnt, lat, busyOk);
    checkOutput("ignStartLatency", lat, LATENCY);
    checkOutput("ignStartLabel", lbl, 4);
    checkOutput("ignStartVotes", cnt, 1);
    @(posedge clk); #1;
    applyStimulus(vecs[1].d, vecs[1].l, 1'b0, lbl, cnt, lat, busyOk);
    checkOutput("b2bLatency", lat, LATENCY);
    checkOutput("b2bLabel", lbl, vecs[1].expLbl);
    checkOutput("b2bVotes", cnt, 2);
    doneSeen = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) doneSeen++;
    end
    checkOutput("spuriousDone", doneSeen, 0);

    // Reset in the middle of READ, then a clean run must not see leftover votes
    for (int j = 0; j < NBR_KNN; j++) begin
      memD[j] = 32'd1;
      memL[j] = 8'd5;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int n = 0; n < 20; n++) begin
      if (rd_en === 1'b1 && rd_addr === 2'd2) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("rstReachAddr2", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rstMidBusy", busy, 0);
    checkOutput("rstMidDone", done, 0);
    checkOutput("rstMidRdEn", rd_en, 0);
    checkOutput("rstMidRdAddr", rd_addr, 0);
    checkOutput("rstMidLabel", label_out, 0);
    checkOutput("rstMidVotes", vote_cnt, 0);
    @(posedge clk); #1;
    checkOutput("rstStaysIdle", busy, 0);
    applyStimulus(vecs[4].d, vecs[4].l, 1'b0, lbl, cnt, lat, busyOk);
    checkOutput("postRstLatency", lat, LATENCY);
    checkOutput("postRstLabel", lbl, 1);
    checkOutput("postRstVotes", cnt, 4);

    // Result hold while the list changes underneath with no start
    for (int j = 0; j < NBR_KNN; j++) begin
      memD[j] = 32'd3;
      memL[j] = 8'd7;
    end
    holdOk   = 1'b1;
    doneSeen = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (label_out !== 8'd1 || vote_cnt !== 3'd4) holdOk = 1'b0;
      if (done === 1'b1) doneSeen++;
    end
    checkOutput("holdResult", holdOk, 1);
    checkOutput("holdNoDone", doneSeen, 0);

    // Randomized lists: small distance range and labels past NBR_CLASSES to exercise ties and skips
    for (int r = 0; r < 24; r++) begin
      for (int j = 0; j < NBR_KNN; j++) begin
        rd[j] = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 12));
        rl[j] = 8'($urandom_range(0, 12));
      end
      refModel(rd, rl, mLbl, mCnt);
      @(posedge clk); #1;
      applyStimulus(rd, rl, 1'b0, lbl, cnt, lat, busyOk);
      checkOutput("rndLatency", lat, LATENCY);
      checkOutput("rndLabel", lbl, mLbl);
      checkOutput("rndVotes", cnt, mCnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
